// File: rtl/data_memory_io_if.sv
// Load/store bus between the CPU and the data memory / I/O block.
// The CPU side is the master; the memory block is the slave.
interface data_memory_io_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_in;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [DATA_W-1:0] mem_out;
    logic              mem_out_valid;
    logic              busy;

    modport master (
        output mem_access_addr, mem_in, mem_write_en, mem_read_en,
        input  mem_out, mem_out_valid, busy
    );

    modport slave (
        input  mem_access_addr, mem_in, mem_write_en, mem_read_en,
        output mem_out, mem_out_valid, busy
    );
endinterface

// File: rtl/data_memory_io.sv
// Single-port data RAM with registered write-first read, zero-clear after reset,
// and a memory-mapped I/O register bank selected by the address MSB.
module data_memory_io #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH_LOG2     = 5,
    parameter int IO_PORTS       = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    data_memory_io_if.slave            bus,
    output logic [IO_PORTS*DATA_W-1:0] io_out,
    input  logic [IO_PORTS*DATA_W-1:0] io_in,
    output logic [IO_PORTS-1:0]        io_strobe
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int IO_W  = $clog2(IO_PORTS);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clear_ptr;
    logic [DATA_W-1:0]     ram [DEPTH];

    logic                  io_sel;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [IO_W-1:0]       io_idx;
    logic                  wr_go;
    logic                  rd_go;
    logic [DATA_W-1:0]     io_rd_word;
    logic [DATA_W-1:0]     rd_word;
    logic                  unused_addr;

    // Upper address bits are deliberately ignored so both regions alias.
    assign io_sel      = bus.mem_access_addr[ADDR_W-1];
    assign ram_idx     = bus.mem_access_addr[DEPTH_LOG2-1:0];
    assign io_idx      = bus.mem_access_addr[IO_W-1:0];
    assign unused_addr = ^bus.mem_access_addr;

    assign wr_go = bus.mem_write_en && (state == ST_READY);
    assign rd_go = bus.mem_read_en  && (state == ST_READY);

    always_comb begin
        io_rd_word = '0;
        for (int k = 0; k < IO_PORTS; k++) begin
            if (io_idx == IO_W'(k)) io_rd_word = io_in[k*DATA_W +: DATA_W];
        end
    end

    // A simultaneous write wins over the stored word in either region.
    always_comb begin
        if (bus.mem_write_en)
            rd_word = bus.mem_in;
        else if (io_sel)
            rd_word = io_rd_word;
        else
            rd_word = ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            ram[clear_ptr] <= '0;
        else if (wr_go && !io_sel)
            ram[ram_idx] <= bus.mem_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            bus.busy          <= (CLEAR_ON_RESET != 0);
            clear_ptr         <= '0;
            bus.mem_out       <= '0;
            bus.mem_out_valid <= 1'b0;
            io_out            <= '0;
            io_strobe         <= '0;
        end else begin
            bus.mem_out_valid <= rd_go;
            bus.mem_out       <= rd_go ? rd_word : '0;
            io_strobe         <= '0;
            case (state)
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (&clear_ptr) begin
                        state    <= ST_READY;
                        bus.busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (wr_go && io_sel) begin
                        for (int k = 0; k < IO_PORTS; k++) begin
                            if (io_idx == IO_W'(k)) begin
                                io_out[k*DATA_W +: DATA_W] <= bus.mem_in;
                                io_strobe[k]               <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_io.sv
// Randomised bench for data_memory_io: a behavioural model predicts every output
// each cycle, and directed literal checks pin the model on the key scenarios.
module tb_data_memory_io;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int DEPTH    = 32;
    localparam int IO_PORTS = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [IO_PORTS*DATA_W-1:0] io_out;
    logic [IO_PORTS*DATA_W-1:0] io_in = '0;
    logic [IO_PORTS-1:0]        io_strobe;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    data_memory_io_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_io #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(5),
        .IO_PORTS(IO_PORTS), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .io_out(io_out), .io_in(io_in), .io_strobe(io_strobe)
    );

    always #5 clk = ~clk;

    // Behavioural model: busy countdown, RAM array, I/O register array.
    logic [DATA_W-1:0]   m_ram [DEPTH];
    logic [DATA_W-1:0]   m_io  [IO_PORTS];
    logic [DATA_W-1:0]   exp_out;
    logic                exp_valid;
    logic [IO_PORTS-1:0] exp_strobe;
    int                  clear_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
            for (int i = 0; i < IO_PORTS; i++) m_io[i] = '0;
            exp_out = '0; exp_valid = 1'b0; exp_strobe = '0;
        end else begin
            int ri, ii;
            logic io;
            exp_out = '0; exp_valid = 1'b0; exp_strobe = '0;
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                io = bus.mem_access_addr[ADDR_W-1];
                ri = int'(bus.mem_access_addr) % DEPTH;
                ii = int'(bus.mem_access_addr) % IO_PORTS;
                if (bus.mem_read_en) begin
                    exp_valid = 1'b1;
                    if (bus.mem_write_en) exp_out = bus.mem_in;
                    else if (io)          exp_out = io_in[ii*DATA_W +: DATA_W];
                    else                  exp_out = m_ram[ri];
                end
                if (bus.mem_write_en) begin
                    if (io) begin
                        m_io[ii] = bus.mem_in;
                        exp_strobe[ii] = 1'b1;
                    end else begin
                        m_ram[ri] = bus.mem_in;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IO_PORTS*DATA_W-1:0] model_io_out();
        logic [IO_PORTS*DATA_W-1:0] v;
        for (int k = 0; k < IO_PORTS; k++) v[k*DATA_W +: DATA_W] = m_io[k];
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_mem_out",   bus.mem_out,       exp_out);
            chk("cmp_valid",     bus.mem_out_valid, exp_valid);
            chk("cmp_busy",      bus.busy,          clear_left > 0);
            chk("cmp_io_out",    io_out,            model_io_out());
            chk("cmp_io_strobe", io_strobe,         exp_strobe);
        end
    end

    task automatic do_op(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
        bus.mem_write_en    = wr;
        bus.mem_read_en     = rd;
        bus.mem_access_addr = a;
        bus.mem_in          = d;
        @(posedge clk); #1;
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b0;
    endtask

    // Releases reset and counts cycles until busy drops; optionally injects a
    // write/read to 0x0004 during the clear.
    task automatic release_and_wait(input string name, input bit poke);
        int cnt;
        rst_n = 1'b1;
        cnt = 0;
        while (cnt < 100) begin
            if (poke && cnt == 3) begin
                do_op(1'b1, 1'b1, 16'h0004, 16'hFFFF);
                chk("busy_write_valid", bus.mem_out_valid, 1'b0);
                chk("busy_write_strobe", io_strobe, '0);
            end else begin
                @(posedge clk); #1;
            end
            cnt++;
            if (!bus.busy) break;
        end
        chk(name, cnt, 32);
    endtask

    initial begin
        bus.mem_access_addr = '0;
        bus.mem_in          = '0;
        bus.mem_write_en    = 1'b0;
        bus.mem_read_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_busy",  bus.busy, 1'b1);
        chk("reset_out",   bus.mem_out, 16'h0000);
        chk("reset_valid", bus.mem_out_valid, 1'b0);

        release_and_wait("busy_len_first", 1'b1);

        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b0, 1'b1, 16'(i), 16'h0);
            chk("clear_read", {bus.mem_out_valid, bus.mem_out}, {1'b1, 16'h0000});
        end

        do_op(1'b1, 1'b0, 16'h0003, 16'hBEEF);
        do_op(1'b0, 1'b1, 16'h0003, 16'h0);
        chk("read_beef", {bus.mem_out_valid, bus.mem_out}, {1'b1, 16'hBEEF});
        do_op(1'b0, 1'b1, 16'h0023, 16'h0);
        chk("read_wrap", bus.mem_out, 16'hBEEF);

        do_op(1'b1, 1'b1, 16'h0007, 16'h1234);
        chk("write_first", {bus.mem_out_valid, bus.mem_out}, {1'b1, 16'h1234});
        do_op(1'b0, 1'b1, 16'h0007, 16'h0);
        chk("read_after_wf", bus.mem_out, 16'h1234);

        do_op(1'b1, 1'b0, 16'h8002, 16'h00A5);
        chk("io_port2", io_out[2*DATA_W +: DATA_W], 16'h00A5);
        chk("io_strobe", io_strobe, 4'b0100);
        io_in[1*DATA_W +: DATA_W] = 16'h5A5A;
        do_op(1'b0, 1'b1, 16'h8001, 16'h0);
        chk("io_strobe_drop", io_strobe, 4'b0000);
        chk("io_read", {bus.mem_out_valid, bus.mem_out}, {1'b1, 16'h5A5A});
        do_op(1'b0, 1'b0, 16'h0000, 16'h0);
        chk("idle_out", {bus.mem_out_valid, bus.mem_out}, 17'h0);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[14:5] = '0;
            io_in = {$urandom, $urandom};
            do_op(1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        rst_n = 1'b0;
        #1;
        release_and_wait("busy_len_second", 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midclear_out",    {bus.mem_out_valid, bus.mem_out}, 17'h0);
        chk("midclear_io",     io_out, '0);
        chk("midclear_strobe", io_strobe, '0);
        chk("midclear_busy",   bus.busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        release_and_wait("busy_len_restart", 1'b0);
        do_op(1'b0, 1'b1, 16'h0003, 16'h0);
        chk("restart_cleared", bus.mem_out, 16'h0000);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
